// File: rtl/apb_pkg.sv
// Shared types and strobe helpers for the APB RAM completer.
// Pure definitions, no logic or latency of its own.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Access size in bytes for a low-aligned strobe; 0 marks an illegal pattern.
    function automatic logic [2:0] strb_size(input logic [3:0] strb);
        case (strb)
            STRB_B:  return 3'd1;
            STRB_H:  return 3'd2;
            STRB_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane alignment between low-aligned APB data and the word-organised RAM.
// Purely combinational, zero latency; no flow control of its own.
module apb_lane_align
    import apb_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  pstrb,
    input  logic [31:0] pwdata,
    input  logic [31:0] rdata_word,
    output logic [31:0] wdata_sh,
    output logic [3:0]  lane_mask,
    output logic [31:0] rdata_sh,
    output logic        misalign
);

    logic [2:0] size;

    assign size      = strb_size(pstrb);
    assign wdata_sh  = pwdata << {off, 3'b000};
    assign lane_mask = pstrb << off;
    assign rdata_sh  = rdata_word >> {off, 3'b000};
    // Illegal strobe or an access that would spill past byte lane 3.
    assign misalign  = (size == 3'd0) || (({1'b0, off} + size) > 3'd4);

endmodule

// File: rtl/apb_ram_completer.sv
// APB completer in front of a word RAM with sub-word stores and byte-aligned reads.
// Completes WAIT_STATES+1 access cycles after setup; pready is the only stall mechanism.
module apb_ram_completer
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  strb_q;
    logic        write_q, err_q;
    logic        pready_d, pslverr_d, latch, ram_we;
    logic [31:0] prdata_d;

    logic [31:0] cur_addr, cur_wdata, rel_addr;
    logic [3:0]  cur_strb;
    logic        cur_write, in_range, err_new, err_cur;
    logic [AW-1:0] idx;
    logic [31:0] rdata_word, wdata_sh, rdata_sh, rd_val;
    logic [3:0]  lane_mask;
    logic        misalign;

    logic [31:0] mem [DEPTH];

    // In IDLE the live bus is decoded (setup cycle); afterwards the latched copy is used.
    assign cur_addr  = (state == IDLE) ? paddr  : addr_q;
    assign cur_wdata = (state == IDLE) ? pwdata : wdata_q;
    assign cur_strb  = (state == IDLE) ? pstrb  : strb_q;
    assign cur_write = (state == IDLE) ? pwrite : write_q;

    // Unsigned wrap makes addresses below BASE_ADDR land outside SPAN too.
    assign rel_addr   = cur_addr - BASE_ADDR;
    assign in_range   = rel_addr < SPAN;
    assign idx        = rel_addr[AW+1:2];
    assign rdata_word = mem[idx];
    assign err_new    = !in_range || (cur_write && misalign);
    assign err_cur    = (state == IDLE) ? err_new : err_q;
    assign rd_val     = err_cur ? 32'd0 : rdata_sh;

    apb_lane_align u_align (
        .off        (cur_addr[1:0]),
        .pstrb      (cur_strb),
        .pwdata     (cur_wdata),
        .rdata_word (rdata_word),
        .wdata_sh   (wdata_sh),
        .lane_mask  (lane_mask),
        .rdata_sh   (rdata_sh),
        .misalign   (misalign)
    );

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata;
        latch     = 1'b0;
        ram_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = err_cur;
                        prdata_d  = rd_val;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt == 4'd1) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = err_cur;
                    prdata_d  = rd_val;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ram_we  = psel && penable && write_q && !err_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            prdata  <= 32'd0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            strb_q  <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            prdata  <= prdata_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            if (latch) begin
                addr_q  <= paddr;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                write_q <= pwrite;
                err_q   <= err_new;
            end
        end
    end

    // RAM is not reset; ram_we is forced low by the async state reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/apb_ram_completer.md
Name: apb_ram_completer

Overview:
APB completer (responder) fronting a word-organised on-chip RAM. It is the far end of the core's APB initiator port, serving instruction fetch, load/store and the sys-region accesses. It returns byte-aligned read data (addressed byte in bits [7:0]) so the core's LB/LH/LBU/LHU extraction works unchanged. It lane-shifts and strobes sub-word stores, and has a programmable number of wait states.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of RAM word 0
DEPTH, 1024, number of 32-bit words (power of two)
WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  32  byte address
pwdata  in  32  store data, low-aligned (SB data in [7:0], SH data in [15:0])
pstrb  in  4  low-aligned size mask: 4'b0001 byte, 4'b0011 half, 4'b1111 word; ignored on reads
prdata  out  32  read data, right-shifted by paddr[1:0]*8
pready  out  1  transfer completes this cycle
pslverr  out  1  error response, valid only while pready=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0. No RAM write occurs in a reset cycle. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on psel=1 & penable=0 (setup), latch paddr, pwrite, pwdata, pstrb, and compute err. If WAIT_STATES=0, go to RESP and register pready=1 for the first access cycle. Otherwise load counter=WAIT_STATES and go to WAIT.
- WAIT: pready=0. Decrement the counter each cycle. When counter==1, register pready=1 and go to RESP. Latency from setup to completion is WAIT_STATES+1 access cycles.
- RESP: pready=1 for exactly one cycle. Write commit occurs when psel&penable&pwrite&!err: the RAM word at idx = (paddr-BASE_ADDR)>>2 is updated using pwdata<<(8*off) under lane mask pstrb<<off, where off=paddr[1:0]. Next state is IDLE and pready falls.
- Read data: prdata is registered in the same edge that sets pready: prdata = RAM[idx] >> (8*off), zero-filled. On err, prdata=0. Otherwise prdata holds its last value.
- err conditions:
  - paddr outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
  - Write with pstrb not in {0001, 0011, 1111}.
  - Write with off+size>4 (half at off=3, word at off≠0).
  - Reads never fault on alignment.
- pslverr=err while pready=1, else 0. An err write leaves the RAM unchanged.
- Abort: psel=0 while in WAIT or RESP returns to IDLE next cycle with pready=0, no write, prdata unchanged.
- Protocol violation (penable=1 seen in IDLE without a setup) is ignored; stay in IDLE.
- Back-to-back transfers: a new setup cycle is required after RESP, so minimum throughput is one transfer per 2+WAIT_STATES cycles.
- Reset asserted mid-transfer: immediate return to IDLE, outputs cleared, pending write dropped.
- Address arithmetic is 32-bit unsigned. The index uses log2(DEPTH) bits of the offset.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE/WAIT/RESP)
  - strobe constants STRB_B=4'b0001, STRB_H=4'b0011, STRB_W=4'b1111
  - function strb_size(pstrb) returning 1/2/4 or 0 for illegal
- One sub-module, apb_lane_align (combinational): inputs off, pstrb, pwdata, rdata_word; outputs shifted wdata, lane mask, shifted rdata, misalign flag. The RAM array and FSM stay in the top.

Test Plan:
- WAIT_STATES=0, write 32'hDEADBEEF at BASE+8, strb 1111, then read BASE+8 -> pready high in first access cycle each time; read returns 32'hDEADBEEF, pslverr=0.
- SB pwdata=32'h000000A5, strb 0001 to BASE+9 over word 32'h11223344 -> word becomes 32'h1122A544. Read BASE+9 -> prdata=32'h001122A5.
- WAIT_STATES=3, read -> pready low for 3 access cycles and high on the 4th. prdata stable and valid only with pready.
- SH at BASE+3 and read at BASE+4*DEPTH -> both complete with pready=1, pslverr=1. RAM unchanged; read prdata=0.
- Write setup then psel dropped during WAIT (WAIT_STATES=2) -> no RAM change, FSM back in IDLE, next transfer completes normally.
- rst_n pulsed low during RESP of a write -> pready/pslverr/prdata=0 immediately; target word keeps its old value.
